imem_loader: RTL and testbench

- Writer side of the core's instruction ROM. It replaces testbench `assign`s into `rom_data` with a real load path.
- Accepts a byte stream over a valid/ready handshake: 2-byte little-endian word count, then 4 bytes per instruction, little-endian.
- Assembles 32-bit words and writes them to sequential ROM addresses from 0.
- Holds the core in reset until the load completes.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/imem_word_packer.sv | 36 +++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width and the instruction-loader state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses for one
// cycle after the fourth byte of each word is taken.
module imem_word_packer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            byte_en,
  input  logic [7:0]      byte_in,
  output logic [XLEN-1:0] word_out,
  output logic            word_valid
);

  logic [1:0] idx;

  // word_out holds the finished word through the word_valid cycle; the next
  // word's first byte only lands at the edge that ends it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx        <= 2'd0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        idx <= 2'd0;
      end else if (byte_en) begin
        word_out[{idx, 3'b000} +: 8] <= byte_in;
        idx                          <= idx + 2'd1;
        word_valid                   <= (idx == 2'd3);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction ROM writer: takes a 16-bit word count then little-endian words over
// a byte handshake, writes them from address 0 and holds the core until done.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_hold,
  output logic            done,
  output logic            err,
  output logic [AW:0]     words_loaded
);

  loader_state_t   state, state_nxt;
  logic [7:0]      count_lo;
  logic [15:0]     count;
  logic [15:0]     hdr_count;
  logic            arm;
  logic            byte_en;
  logic            word_valid;
  logic            last_word;
  logic [XLEN-1:0] word;

  assign hdr_count = {in_data, count_lo};
  assign arm       = start && (state == IDLE || state == DONE || state == ERR);
  assign byte_en   = in_valid && (state == DATA);
  assign last_word = word_valid && ((16'(words_loaded) + 16'd1) == count);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (arm),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word_out   (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // HDR0/HDR1 test in_valid directly: in_ready is always high there, so this
  // equals the handshake without feeding in_ready back into its own decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    core_hold = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = HDR0;
      end
      HDR0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = HDR1;
      end
      HDR1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (hdr_count == 16'd0)                    state_nxt = DONE;
          else if ({1'b0, hdr_count} > 17'(DEPTH))  state_nxt = ERR;
          else                                       state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
        if (start) state_nxt = HDR0;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = HDR0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_lo     <= 8'd0;
      count        <= 16'd0;
      words_loaded <= '0;
    end else begin
      if (state == HDR0 && in_valid) count_lo <= in_data;
      if (state == HDR1 && in_valid) count    <= hdr_count;
      if (arm)             words_loaded <= '0;
      else if (word_valid) words_loaded <= words_loaded + 1'b1;
    end
  end

  // The write address is the pre-increment count, valid during the strobe cycle.
  assign imem_we    = word_valid;
  assign imem_addr  = words_loaded[AW-1:0];
  assign imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: streams, empty/oversize headers,
// stalls, mid-load reset and a full-depth load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  int checks   = 0;
  int failures = 0;

  int          wrCount    = 0;
  int          longStrobe = 0;
  logic        prevWe     = 1'b0;
  logic [7:0]  wrAddr [0:299];
  logic [31:0] wrData [0:299];

  imem_loader #(.DEPTH(256), .AW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Records every write strobe and flags strobes lasting more than one cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      if (wrCount < 300) begin
        wrAddr[wrCount] = imem_addr;
        wrData[wrCount] = imem_wdata;
      end
      wrCount = wrCount + 1;
      if (prevWe) longStrobe = longStrobe + 1;
    end
    prevWe = imem_we;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      failures = failures + 1;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Offers one byte from a negedge and returns just after the edge that takes it.
  task automatic applyStimulus(input logic [7:0] b, input logic st);
    int waitCycles;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    waitCycles = 0;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      start = 1'b0;
      waitCycles++;
    end
    if (!in_ready) checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic endStream();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hFF;
      start    = 1'b0;
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input logic st);
    applyStimulus(w[7:0], st);
    applyStimulus(w[15:8], 1'b0);
    applyStimulus(w[23:16], 1'b0);
    applyStimulus(w[31:24], 1'b0);
  endtask

  initial begin
    int base;
    int badData;
    logic [31:0] w;

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state, with start held high alongside reset
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready",   {31'd0, in_ready},  32'd0);
    checkOutput("rst_imem_we",    {31'd0, imem_we},   32'd0);
    checkOutput("rst_imem_addr",  {24'd0, imem_addr}, 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata,         32'd0);
    checkOutput("rst_core_hold",  {31'd0, core_hold}, 32'd1);
    checkOutput("rst_done",       {31'd0, done},      32'd0);
    checkOutput("rst_err",        {31'd0, err},       32'd0);
    checkOutput("rst_words",      {23'd0, words_loaded}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_hold", {31'd0, core_hold}, 32'd1);

    // Two-word load, continuous valid
    $display("[TB] two-word load");
    base = wrCount;
    pulseStart();
    checkOutput("t1_hdr0_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h00, 1'b0);
    sendWord(32'h00208033, 1'b0);
    sendWord(32'h00208033, 1'b0);
    endStream();
    checkOutput("t1_we_last",   {31'd0, imem_we},   32'd1);
    checkOutput("t1_hold_last", {31'd0, core_hold}, 32'd1);
    @(negedge clk);
    checkOutput("t1_done",    {31'd0, done},         32'd1);
    checkOutput("t1_hold",    {31'd0, core_hold},    32'd0);
    checkOutput("t1_words",   {23'd0, words_loaded}, 32'd2);
    checkOutput("t1_ready",   {31'd0, in_ready},     32'd0);
    checkOutput("t1_nwrites", wrCount - base,        32'd2);
    checkOutput("t1_addr0",   {24'd0, wrAddr[base]},   32'd0);
    checkOutput("t1_data0",   wrData[base],            32'h00208033);
    checkOutput("t1_addr1",   {24'd0, wrAddr[base+1]}, 32'd1);
    checkOutput("t1_data1",   wrData[base+1],          32'h00208033);
    checkOutput("t1_strobe",  longStrobe,              32'd0);

    // Empty load goes straight to DONE
    $display("[TB] zero-count load");
    base = wrCount;
    pulseStart();
    checkOutput("t2_rearm_hold", {31'd0, core_hold}, 32'd1);
    checkOutput("t2_rearm_done", {31'd0, done},      32'd0);
    checkOutput("t2_rearm_words", {23'd0, words_loaded}, 32'd0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    endStream();
    checkOutput("t2_done",  {31'd0, done},         32'd1);
    checkOutput("t2_hold",  {31'd0, core_hold},    32'd0);
    checkOutput("t2_words", {23'd0, words_loaded}, 32'd0);
    idleCycles(2);
    checkOutput("t2_nwrites", wrCount - base, 32'd0);

    // Count 257 exceeds depth
    $display("[TB] oversize count");
    base = wrCount;
    pulseStart();
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h01, 1'b0);
    endStream();
    checkOutput("t3_err",   {31'd0, err},       32'd1);
    checkOutput("t3_hold",  {31'd0, core_hold}, 32'd1);
    checkOutput("t3_ready", {31'd0, in_ready},  32'd0);
    checkOutput("t3_done",  {31'd0, done},      32'd0);
    idleCycles(3);
    checkOutput("t3_still_err", {31'd0, err}, 32'd1);
    checkOutput("t3_nwrites",   wrCount - base, 32'd0);
    pulseStart();
    checkOutput("t3_clr_err", {31'd0, err},      32'd0);
    checkOutput("t3_hdr0",    {31'd0, in_ready}, 32'd1);

    // One word with valid gaps, continuing from the HDR0 armed above
    $display("[TB] stalled one-word load");
    base = wrCount;
    w = 32'h00308093;
    applyStimulus(8'h01, 1'b0);
    idleCycles(2);
    applyStimulus(8'h00, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[8*i +: 8], 1'b0);
      if (i < 3) idleCycles(2);
    end
    endStream();
    @(negedge clk);
    checkOutput("t4_done",    {31'd0, done},         32'd1);
    checkOutput("t4_words",   {23'd0, words_loaded}, 32'd1);
    checkOutput("t4_nwrites", wrCount - base,        32'd1);
    checkOutput("t4_addr0",   {24'd0, wrAddr[base]}, 32'd0);
    checkOutput("t4_data0",   wrData[base],          32'h00308093);

    // Reset after two data bytes of a three-word load
    $display("[TB] mid-load reset");
    pulseStart();
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("t5_ready", {31'd0, in_ready},     32'd0);
    checkOutput("t5_we",    {31'd0, imem_we},      32'd0);
    checkOutput("t5_addr",  {24'd0, imem_addr},    32'd0);
    checkOutput("t5_wdata", imem_wdata,            32'd0);
    checkOutput("t5_hold",  {31'd0, core_hold},    32'd1);
    checkOutput("t5_done",  {31'd0, done},         32'd0);
    checkOutput("t5_err",   {31'd0, err},          32'd0);
    checkOutput("t5_words", {23'd0, words_loaded}, 32'd0);
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_idle", {31'd0, in_ready}, 32'd0);
    base = wrCount;
    pulseStart();
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    sendWord(32'h11223344, 1'b0);
    endStream();
    @(negedge clk);
    checkOutput("t5_new_done",  {31'd0, done},         32'd1);
    checkOutput("t5_nwrites",   wrCount - base,        32'd1);
    checkOutput("t5_new_addr",  {24'd0, wrAddr[base]}, 32'd0);
    checkOutput("t5_new_data",  wrData[base],          32'h11223344);

    // Full-depth load with a start pulse during DATA
    $display("[TB] full-depth load");
    base = wrCount;
    pulseStart();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    for (int i = 0; i < 256; i++) begin
      w = {8'h5A, ~i[7:0], 8'hA0, i[7:0]};
      sendWord(w, (i == 100));
    end
    endStream();
    checkOutput("t6_last_addr", {24'd0, imem_addr}, 32'd255);
    @(negedge clk);
    checkOutput("t6_done",    {31'd0, done},         32'd1);
    checkOutput("t6_hold",    {31'd0, core_hold},    32'd0);
    checkOutput("t6_words",   {23'd0, words_loaded}, 32'd256);
    checkOutput("t6_nwrites", wrCount - base,        32'd256);
    badData = 0;
    for (int i = 0; i < 256; i++) begin
      w = {8'h5A, ~i[7:0], 8'hA0, i[7:0]};
      if (wrAddr[base+i] !== i[7:0] || wrData[base+i] !== w) badData++;
    end
    checkOutput("t6_all_writes", badData,           32'd0);
    checkOutput("t6_final_addr", {24'd0, wrAddr[base+255]}, 32'd255);
    checkOutput("t6_strobe",     longStrobe,         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
